block_dispatcher: RTL and testbench
===================================

Name: block_dispatcher

Overview:
- Successor to the static per-core thread split at the GPU top level. Holds the kernel launch registers and hands thread blocks out dynamically: each block goes to the first free core, and a core is refilled as soon as it finishes.
- Supports wide thread counts, a programmable block size and any core count.
- Sits between the device control interface and the core array. It drives each core's start, reset, block id and thread count, and aggregates completion into `done`.

Parameters:
- NUM_CORES, 4, number of cores served.
- THREAD_COUNT_BITS, 16, width of the total thread count and of block ids.
- BLOCK_DIM_BITS, 8, width of the threads-per-block value.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- device_control_write_enable  in  1  register write strobe.
- device_control_addr  in  2  register select: 0 = thread_count[7:0], 1 = thread_count[15:8], 2 = block_dim, 3 = ignored.
- device_control_data  in  8  write data.
- start  in  1  level; launches the kernel when seen in IDLE.
- done  out  1  kernel complete, held until start falls.
- busy  out  1  high in any state other than IDLE or DONE.
- block_dim  out  BLOCK_DIM_BITS  current block_dim register value.
- core_start  out  NUM_CORES  per-core start, high while the core is assigned a block.
- core_reset  out  NUM_CORES  per-core active-high reset pulse.
- core_block_id  out  NUM_CORES*THREAD_COUNT_BITS  packed; core i uses bits [i*W +: W].
- core_thread_count  out  NUM_CORES*BLOCK_DIM_BITS  packed; number of threads in the assigned block.
- core_done  in  NUM_CORES  per-core completion.
- kernel_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (reset=0 at a clk edge) applies in any state, including mid-kernel:
  - all registers, including block_dim, clear to 0;
  - top FSM goes to IDLE and every core slot goes to FREE;
  - done=0, busy=0, core_start=0, core_reset=all ones, core_block_id=0, core_thread_count=0, kernel_cycles=0.
  - core_reset drops to 0 on the first cycle out of reset.
- Register writes:
  - Taken only in IDLE or DONE; ignored while busy.
  - Widths wider than 8 bits split across bytes; unused high bits of the thread count are 0.
- Top FSM states are IDLE, DISPATCH, DRAIN and DONE.
  - IDLE with start=1 and thread_count==0 or block_dim==0 → DONE on the next cycle; no core is started.
  - IDLE with start=1 otherwise → DISPATCH. This loads remaining := thread_count and next_id := 0.
  - DISPATCH: at most one assignment per cycle, to the lowest-indexed FREE core.
  - Each assignment registers:
    - core_block_id[i] := next_id;
    - core_thread_count[i] := min(remaining, block_dim);
    - core_start[i] := 1, with the slot moving to RUN;
    - remaining -= count and next_id += 1.
  - The first core_start rises 2 cycles after start is first sampled in IDLE.
  - DISPATCH → DRAIN in the cycle remaining reaches 0.
  - DRAIN → DONE when every slot is FREE.
  - DONE: done=1. DONE → IDLE when start=0; done falls on that transition.
- Per-core slot states are FREE, RUN and RST.
  - RUN with core_done[i]=1 → RST: core_start[i]=0 and core_reset[i]=1 for exactly one cycle.
  - RST → FREE on the next cycle.
  - A FREE slot may be assigned in the same cycle it becomes FREE.
  - core_done is ignored in FREE and RST.
  - core_block_id and core_thread_count hold their last value until reassigned.
- Simultaneous events:
  - Several cores finishing in one cycle each enter RST independently.
  - A core finishing in the cycle remaining reaches 0 is still counted in DRAIN.
- Last block: count = thread_count − (blocks−1)·block_dim, which falls out of the min() rule. No divider is used.
- next_id wraps modulo 2^THREAD_COUNT_BITS. This is unreachable when block_dim ≥ 1.

Optional Feature:
- Macro: DISPATCH_PERF_COUNTER_EN.
- Defined:
  - kernel_cycles clears on the IDLE→DISPATCH transition;
  - it increments every cycle in DISPATCH or DRAIN, saturating at 2^32−1;
  - it holds in DONE and IDLE until the next launch.
- Not defined: kernel_cycles is tied to 0 and no counter logic is built.

Test Plan:
- NUM_CORES=4, thread_count=10, block_dim=4, start=1 at cycle N, all cores stall → core_start[0..2] rise at N+2, N+3, N+4. Ids 0/1/2, counts 4/4/2. core_start[3] stays 0.
- thread_count=0 (block_dim=4), start=1 → done=1 on the next cycle with no core_start. Drop start → done=0 and the FSM returns to IDLE.
- thread_count=36, block_dim=4 (9 blocks). Pulse core_done[2] after core 2 starts → one-cycle core_reset[2]; core 2 gets id 4 next. All 9 blocks are dispatched; done rises after the last core_done and its RST cycle.
- While busy, write device_control_addr=2, data=1 → block_dim stays 4 and the kernel result is unchanged. The same write in DONE takes effect.
- Mid-DISPATCH, hold reset=0 for 1 cycle → core_start=0, core_reset=all ones, done=0, busy=0. A relaunch with thread_count=4 and block_dim=4 sends one block of 4 to core 0.
- With DISPATCH_PERF_COUNTER_EN defined, a single block whose core_done arrives 5 cycles after its core_start rose → kernel_cycles = 8 (1 dispatch + 1 + 5 + 1 RST/drain). With the macro undefined → kernel_cycles = 0.

Source files
------------

// File: rtl/block_dispatcher.sv
// block_dispatcher: holds the kernel launch registers and hands thread blocks
// out dynamically to a core array. Each block goes to the lowest-indexed free
// core; a core is refilled as soon as it completes and passes its reset cycle.
//
// Ports:
//   clk, reset (sync, active-low)
//   device_control_write_enable/addr/data : launch register writes
//                                           (0 = thread_count[7:0], 1 = thread_count[15:8],
//                                            2 = block_dim, 3 = ignored)
//   start            : level; launches the kernel from IDLE
//   done             : kernel complete, held until start falls
//   busy             : high while dispatching or draining
//   block_dim        : current threads-per-block register
//   core_start       : per-core start, high while a block is assigned
//   core_reset       : per-core one-cycle reset pulse after completion
//   core_block_id    : packed per-core block id, core i at [i*W +: W]
//   core_thread_count: packed per-core thread count of the assigned block
//   core_done        : per-core completion
//   kernel_cycles    : cycle counter, built only when DISPATCH_PERF_COUNTER_EN
//                      is defined; otherwise tied to 0
module block_dispatcher #(
   parameter int unsigned NUM_CORES         = 4,
   parameter int unsigned THREAD_COUNT_BITS = 16,
   parameter int unsigned BLOCK_DIM_BITS    = 8
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    device_control_write_enable,
   input  logic [1:0]                              device_control_addr,
   input  logic [7:0]                              device_control_data,
   input  logic                                    start,
   output logic                                    done,
   output logic                                    busy,
   output logic [BLOCK_DIM_BITS-1:0]               block_dim,
   output logic [NUM_CORES-1:0]                    core_start,
   output logic [NUM_CORES-1:0]                    core_reset,
   output logic [NUM_CORES*THREAD_COUNT_BITS-1:0]  core_block_id,
   output logic [NUM_CORES*BLOCK_DIM_BITS-1:0]     core_thread_count,
   input  logic [NUM_CORES-1:0]                    core_done,
   output logic [31:0]                             kernel_cycles
);

   localparam int unsigned TW    = THREAD_COUNT_BITS;
   localparam int unsigned BW    = BLOCK_DIM_BITS;
   localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;
   typedef enum logic [1:0] {S_FREE, S_RUN, S_RST} slot_t;

   state_t           state;
   slot_t            slot [NUM_CORES];
   logic [7:0]       tc_lo;
   logic [7:0]       tc_hi;
   logic [TW-1:0]    thread_count;
   logic [TW-1:0]    remaining;
   logic [TW-1:0]    next_id;

   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic             any_run;
   logic [BW-1:0]    blk_cnt;
   logic             regs_open;

   assign thread_count = TW'({tc_hi, tc_lo});
   assign regs_open    = (state == IDLE) || (state == DONE);

   // Lowest free slot, whether any slot is still running, and the next block size
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      any_run    = 1'b0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (slot[i] == S_FREE) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (slot[i] == S_RUN) any_run = 1'b1;
      end
      blk_cnt = (remaining < TW'(block_dim)) ? BW'(remaining) : block_dim;
   end

   // Launch registers, top FSM and per-core slots
   always_ff @(posedge clk) begin
      if (!reset) begin
         state             <= IDLE;
         tc_lo             <= '0;
         tc_hi             <= '0;
         block_dim         <= '0;
         remaining         <= '0;
         next_id           <= '0;
         done              <= 1'b0;
         busy              <= 1'b0;
         core_start        <= '0;
         core_reset        <= '1;
         core_block_id     <= '0;
         core_thread_count <= '0;
         for (int i = 0; i < NUM_CORES; i++) slot[i] <= S_FREE;
      end else begin
         core_reset <= '0;

         for (int i = 0; i < NUM_CORES; i++) begin
            case (slot[i])
               S_RUN: if (core_done[i]) begin
                  slot[i]       <= S_RST;
                  core_start[i] <= 1'b0;
                  core_reset[i] <= 1'b1;
               end
               S_RST:   slot[i] <= S_FREE;
               default: ;
            endcase
         end

         if (regs_open && device_control_write_enable) begin
            case (device_control_addr)
               2'd0:    tc_lo     <= device_control_data;
               2'd1:    tc_hi     <= device_control_data;
               2'd2:    block_dim <= BW'(device_control_data);
               default: ;
            endcase
         end

         case (state)
            IDLE: if (start) begin
               if (thread_count == '0 || block_dim == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state     <= DISPATCH;
                  busy      <= 1'b1;
                  remaining <= thread_count;
                  next_id   <= '0;
               end
            end
            DISPATCH: if (free_found) begin
               // Slot being assigned is FREE, so the slot loop above left it alone
               slot[free_idx]                          <= S_RUN;
               core_start[free_idx]                    <= 1'b1;
               core_block_id[free_idx*TW +: TW]        <= next_id;
               core_thread_count[free_idx*BW +: BW]    <= blk_cnt;
               remaining                               <= remaining - TW'(blk_cnt);
               next_id                                 <= next_id + TW'(1);
               if (remaining == TW'(blk_cnt)) state <= DRAIN;
            end
            // A slot in RST is free next cycle, so only running slots hold DRAIN
            DRAIN: if (!any_run) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            DONE: if (!start) begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DISPATCH_PERF_COUNTER_EN
   logic launch;
   assign launch = (state == IDLE) && start && (thread_count != '0) && (block_dim != '0);

   // Saturating count of DISPATCH/DRAIN cycles for the current kernel
   always_ff @(posedge clk) begin
      if (!reset) begin
         kernel_cycles <= '0;
      end else if (launch) begin
         kernel_cycles <= '0;
      end else if ((state == DISPATCH || state == DRAIN) && kernel_cycles != '1) begin
         kernel_cycles <= kernel_cycles + 32'd1;
      end
   end
`else
   assign kernel_cycles = '0;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher (NUM_CORES=4, 16-bit thread count, 8-bit block_dim).
module tb_block_dispatcher;

   logic        clk;
   logic        reset;
   logic        we;
   logic [1:0]  addr;
   logic [7:0]  data;
   logic        start;
   logic        done;
   logic        busy;
   logic [7:0]  block_dim;
   logic [3:0]  core_start;
   logic [3:0]  core_reset;
   logic [63:0] core_block_id;
   logic [31:0] core_thread_count;
   logic [3:0]  core_done;
   logic [31:0] kernel_cycles;

   int pass_cnt  = 0;
   int total_cnt = 0;

`ifdef DISPATCH_PERF_COUNTER_EN
   localparam logic [31:0] EXP_CYCLES = 32'd8;
`else
   localparam logic [31:0] EXP_CYCLES = 32'd0;
`endif

   block_dispatcher dut (
      .clk                         (clk),
      .reset                       (reset),
      .device_control_write_enable (we),
      .device_control_addr         (addr),
      .device_control_data         (data),
      .start                       (start),
      .done                        (done),
      .busy                        (busy),
      .block_dim                   (block_dim),
      .core_start                  (core_start),
      .core_reset                  (core_reset),
      .core_block_id               (core_block_id),
      .core_thread_count           (core_thread_count),
      .core_done                   (core_done),
      .kernel_cycles               (kernel_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
      we = 1'b1; addr = a; data = d;
      tick();
      we = 1'b0;
   endtask

   task automatic setup(input logic [15:0] tc, input logic [7:0] bd);
      write_reg(2'd0, tc[7:0]);
      write_reg(2'd1, tc[15:8]);
      write_reg(2'd2, bd);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(); tick();
      total_cnt++;
      if ({done, busy, core_start, core_reset} !== {1'b0, 1'b0, 4'h0, 4'hf}) begin
         $display("FAIL reset_ctrl got done=%b busy=%b start=%b rst=%b exp 0 0 0000 1111",
                  done, busy, core_start, core_reset);
      end else pass_cnt++;
      total_cnt++;
      if ({core_block_id, core_thread_count, kernel_cycles, block_dim} !== '0) begin
         $display("FAIL reset_regs got id=%h cnt=%h kc=%0d bd=%0d exp all 0",
                  core_block_id, core_thread_count, kernel_cycles, block_dim);
      end else pass_cnt++;
      reset = 1'b1;
      tick();
      total_cnt++;
      if (core_reset !== 4'h0) begin
         $display("FAIL reset_release got core_reset=%b exp 0000", core_reset);
      end else pass_cnt++;
   endtask

   task automatic test_dispatch_stall();
      logic [3:0] exp_seq [3];
      exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0011; exp_seq[2] = 4'b0111;
      setup(16'd10, 8'd4);
      start = 1'b1;
      tick();
      total_cnt++;
      if (core_start !== 4'h0 || busy !== 1'b1) begin
         $display("FAIL stall_first got start=%b busy=%b exp 0000 1", core_start, busy);
      end else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         tick();
         total_cnt++;
         if (core_start !== exp_seq[k]) begin
            $display("FAIL stall_start%0d got %b exp %b", k, core_start, exp_seq[k]);
         end else pass_cnt++;
      end
      tick();
      total_cnt++;
      if (core_block_id[47:0] !== {16'd2, 16'd1, 16'd0} ||
          core_thread_count[23:0] !== {8'd2, 8'd4, 8'd4} || core_start !== 4'b0111) begin
         $display("FAIL stall_assign got id=%h cnt=%h start=%b exp 000200010000 020404 0111",
                  core_block_id[47:0], core_thread_count[23:0], core_start);
      end else pass_cnt++;
      // Write attempted while busy must be dropped
      write_reg(2'd2, 8'd1);
      total_cnt++;
      if (block_dim !== 8'd4) begin
         $display("FAIL busy_write got block_dim=%0d exp 4", block_dim);
      end else pass_cnt++;
      core_done = 4'b0111;
      tick();
      core_done = 4'b0000;
      total_cnt++;
      if (core_reset !== 4'b0111 || core_start !== 4'b0000 || done !== 1'b0) begin
         $display("FAIL stall_finish got rst=%b start=%b done=%b exp 0111 0000 0",
                  core_reset, core_start, done);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if (done !== 1'b1 || busy !== 1'b0 || core_reset !== 4'h0) begin
         $display("FAIL stall_done got done=%b busy=%b rst=%b exp 1 0 0000", done, busy, core_reset);
      end else pass_cnt++;
      write_reg(2'd2, 8'd1);
      total_cnt++;
      if (block_dim !== 8'd1) begin
         $display("FAIL done_write got block_dim=%0d exp 1", block_dim);
      end else pass_cnt++;
      start = 1'b0;
      tick();
      total_cnt++;
      if (done !== 1'b0) begin
         $display("FAIL stall_idle got done=%b exp 0", done);
      end else pass_cnt++;
   endtask

   task automatic test_zero_threads();
      setup(16'd0, 8'd4);
      start = 1'b1;
      tick();
      total_cnt++;
      if (done !== 1'b1 || core_start !== 4'h0 || busy !== 1'b0) begin
         $display("FAIL zero_done got done=%b start=%b busy=%b exp 1 0000 0", done, core_start, busy);
      end else pass_cnt++;
      start = 1'b0;
      tick();
      total_cnt++;
      if (done !== 1'b0) begin
         $display("FAIL zero_idle got done=%b exp 0", done);
      end else pass_cnt++;
   endtask

   task automatic test_refill();
      logic [3:0] prev;
      int blocks, sum, max_id, cyc;
      setup(16'd36, 8'd4);
      start = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      total_cnt++;
      if (core_start !== 4'hf || core_block_id !== {16'd3, 16'd2, 16'd1, 16'd0}) begin
         $display("FAIL refill_fill got start=%b id=%h exp 1111 0003000200010000",
                  core_start, core_block_id);
      end else pass_cnt++;
      core_done = 4'b0100;
      tick();
      core_done = 4'b0000;
      total_cnt++;
      if (core_reset !== 4'b0100 || core_start !== 4'b1011) begin
         $display("FAIL refill_rst got rst=%b start=%b exp 0100 1011", core_reset, core_start);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if (core_reset !== 4'b0000 || core_start !== 4'b1011) begin
         $display("FAIL refill_rst_len got rst=%b start=%b exp 0000 1011", core_reset, core_start);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if (core_start !== 4'hf || core_block_id[47:32] !== 16'd4 || core_thread_count[23:16] !== 8'd4) begin
         $display("FAIL refill_id got start=%b id2=%0d cnt2=%0d exp 1111 4 4",
                  core_start, core_block_id[47:32], core_thread_count[23:16]);
      end else pass_cnt++;
      // Every running core completes one cycle after its start is seen
      prev = core_start; blocks = 5; sum = 20; max_id = 4; cyc = 0;
      while (!done && cyc < 200) begin
         core_done = core_start;
         tick();
         cyc++;
         for (int i = 0; i < 4; i++) begin
            if (core_start[i] && !prev[i]) begin
               blocks++;
               sum += int'(core_thread_count[8*i +: 8]);
               if (int'(core_block_id[16*i +: 16]) > max_id) max_id = int'(core_block_id[16*i +: 16]);
            end
         end
         prev = core_start;
      end
      core_done = 4'h0;
      total_cnt++;
      if (done !== 1'b1) begin
         $display("FAIL refill_timeout got done=%b after %0d cycles exp 1", done, cyc);
      end else pass_cnt++;
      total_cnt++;
      if (blocks != 9 || sum != 36 || max_id != 8) begin
         $display("FAIL refill_totals got blocks=%0d threads=%0d max_id=%0d exp 9 36 8",
                  blocks, sum, max_id);
      end else pass_cnt++;
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      setup(16'd36, 8'd4);
      start = 1'b1;
      tick(); tick(); tick();
      reset = 1'b0;
      start = 1'b0;
      tick();
      total_cnt++;
      if ({done, busy, core_start, core_reset, block_dim} !== {1'b0, 1'b0, 4'h0, 4'hf, 8'd0}) begin
         $display("FAIL midrst got done=%b busy=%b start=%b rst=%b bd=%0d exp 0 0 0000 1111 0",
                  done, busy, core_start, core_reset, block_dim);
      end else pass_cnt++;
      reset = 1'b1;
      setup(16'd4, 8'd4);
      start = 1'b1;
      tick(); tick();
      total_cnt++;
      if (core_start !== 4'b0001 || core_block_id[15:0] !== 16'd0 || core_thread_count[7:0] !== 8'd4) begin
         $display("FAIL relaunch got start=%b id0=%0d cnt0=%0d exp 0001 0 4",
                  core_start, core_block_id[15:0], core_thread_count[7:0]);
      end else pass_cnt++;
      core_done = 4'b0001;
      tick();
      core_done = 4'b0000;
      tick();
      total_cnt++;
      if (done !== 1'b1 || core_start !== 4'h0) begin
         $display("FAIL relaunch_done got done=%b start=%b exp 1 0000", done, core_start);
      end else pass_cnt++;
      start = 1'b0;
      tick();
   endtask

   task automatic test_perf();
      setup(16'd4, 8'd4);
      start = 1'b1;
      tick(); tick();
      total_cnt++;
      if (core_start !== 4'b0001) begin
         $display("FAIL perf_start got start=%b exp 0001", core_start);
      end else pass_cnt++;
      for (int k = 0; k < 5; k++) tick();
      core_done = 4'b0001;
      tick();
      core_done = 4'b0000;
      tick();
      total_cnt++;
      if (done !== 1'b1 || kernel_cycles !== EXP_CYCLES) begin
         $display("FAIL perf_cycles got done=%b kc=%0d exp 1 %0d", done, kernel_cycles, EXP_CYCLES);
      end else pass_cnt++;
      start = 1'b0;
      tick(); tick();
      total_cnt++;
      if (kernel_cycles !== EXP_CYCLES) begin
         $display("FAIL perf_hold got kc=%0d exp %0d", kernel_cycles, EXP_CYCLES);
      end else pass_cnt++;
   endtask

   initial begin
      reset = 1'b0; we = 1'b0; addr = 2'd0; data = 8'd0; start = 1'b0; core_done = 4'h0;
      test_reset();
      test_dispatch_stall();
      test_zero_threads();
      test_refill();
      test_reset_mid();
      test_perf();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
